// File: rtl/and_selftest_pkg.sv
// Shared constants and types for the AND-gate self-test sequencer.
// Contents:
//   state_e      - sequencer state encoding (idle, running, finished)
//   NumPatterns  - number of {x,y} patterns applied per run
//   HoldCntW     - width of the per-pattern hold counter
//   and_ref()    - golden AND response for a pattern index {x,y}
package and_selftest_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned NumPatterns = 4;
  localparam int unsigned HoldCntW    = 8;

  // Expected response of a correct AND gate for pattern idx = {x,y}.
  function automatic logic and_ref(input logic [1:0] idx);
    return idx[1] & idx[0];
  endfunction

endpackage

// File: rtl/and_selftest.sv
// Built-in self-test sequencer for an external AND gate (and_struct).
// On start it walks {x,y} through 00, 01, 10, 11, holding each pattern for
// HOLD cycles, compares the returned f against x&y on the last cycle of each
// pattern, and reports the mismatch count and the first failing pattern.
// Ports:
//   clk      - clock, rising edge active
//   rst      - asynchronous active-high reset
//   start    - request a run (ignored while busy)
//   f        - response of the gate under test
//   x, y     - operands driven into the gate under test
//   busy     - run in progress
//   done     - run finished; held until the next run starts or reset
//   pass     - done with zero mismatches
//   err_cnt  - mismatch count of the current/last run (0..4)
//   fail_idx - {x,y} of the first mismatch, 0 when none
module and_selftest
  import and_selftest_pkg::*;
#(
  parameter int unsigned HOLD = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] fail_idx
);

  localparam logic [HoldCntW-1:0] HoldLast = HoldCntW'(HOLD - 1);
  localparam logic [1:0]          LastIdx  = 2'(NumPatterns - 1);
  localparam logic [2:0]          ErrMax   = 3'(NumPatterns);

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [HoldCntW-1:0] hold_q, hold_d;
  logic [2:0]          err_q, err_d;
  logic [1:0]          fail_q, fail_d;
  logic                x_q, x_d;
  logic                y_q, y_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    fail_d  = fail_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      StRun: begin
        if (hold_q == HoldLast) begin
          hold_d = '0;
          if (f != and_ref(idx_q)) begin
            if (err_q < ErrMax) begin
              err_d = err_q + 3'd1;
            end
            if (err_q == 3'd0) begin
              fail_d = idx_q;
            end
          end
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are computed from next state so they are registered yet aligned
    // with the state they describe; pass sees the final compare's err_d.
    x_d    = (state_d == StRun) ? idx_d[1] : 1'b0;
    y_d    = (state_d == StRun) ? idx_d[0] : 1'b0;
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
    pass_d = done_d && (err_d == 3'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_idx = fail_q;

endmodule
